// File: rtl/neosd_card_cmd_pkg.sv
// Shared types and constants for the card-side SD CMD-line engine.
package neosd_card_cmd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_mode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CHECK, S_WAIT, S_TX, S_TURN
  } state_t;

  localparam int         CMD_FRAME_BITS = 48;
  localparam int         RESP_LONG_BITS = 136;
  localparam logic [6:0] CRC7_POLY      = 7'h09;

  // Response frame left-aligned in the 136-bit shifter; the R1 CRC slot is left
  // zero here and the transmitter drives the running CRC in its place.
  function automatic logic [135:0] resp_frame(resp_mode_t mode, logic [5:0] idx,
                                              logic [127:0] data);
    case (mode)
      RESP_R1: resp_frame = {2'b00, idx, data[31:0], 7'h00, 1'b1, 88'h0};
      RESP_R3: resp_frame = {2'b00, 6'h3F, data[31:0], 7'h7F, 1'b1, 88'h0};
      RESP_R2: resp_frame = {2'b00, 6'h3F, data[127:1], 1'b1};
      default: resp_frame = '0;
    endcase
  endfunction

endpackage

// File: rtl/neosd_card_cmd_if.sv
// Back-end handshake between the CMD engine (slave) and the card model (master).
interface neosd_card_cmd_if
  import neosd_card_cmd_pkg::*;
();
  logic         cmd_valid_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_crc_ok_o;
  logic         resp_valid_i;
  resp_mode_t   resp_mode_i;
  logic [5:0]   resp_idx_i;
  logic [127:0] resp_data_i;

  modport slave (
    output cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_crc_ok_o,
    input  resp_valid_i, resp_mode_i, resp_idx_i, resp_data_i
  );

  modport master (
    input  cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_crc_ok_o,
    output resp_valid_i, resp_mode_i, resp_idx_i, resp_data_i
  );
endinterface

// File: rtl/neosd_card_cmd_crc7.sv
// Serial CRC7 (x^7+x^3+1); clear and step in the same cycle starts from zero.
module neosd_crc7
  import neosd_card_cmd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);
  logic [6:0] crc_q, crc_d, base;
  logic       fb;

  always_comb begin
    base  = clr_i ? 7'h00 : crc_q;
    fb    = bit_i ^ base[6];
    crc_d = base;
    if (en_i) crc_d = {base[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD engine: receives host commands, hands them to a back-end, sends responses.
// state | meaning: IDLE wait start bit | RX shift frame | CHECK frame bits | WAIT back-end/Ncr | TX drive response | TURN hold, release
module neosd_card_cmd
  import neosd_card_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NCR_MIN     = 2,
  parameter int NCR_MAX     = 64
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              fsm_rst_i,
  input  logic              sd_clk_i,
  input  logic              sd_cmd_i,
  output logic              sd_cmd_o,
  output logic              sd_cmd_oe,
  neosd_card_cmd_if.slave   bif,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              timeout_o
);
  localparam logic [7:0] NCR_MIN_C = 8'(NCR_MIN);
  localparam logic [7:0] NCR_MAX_C = 8'(NCR_MAX);
  localparam logic [7:0] LAST_RX   = 8'(CMD_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, cmd_sync_q;
  logic                   clk_prev_q, clk_s, cmd_s, rise, fall;

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d, fall_cnt_q, fall_cnt_d, tx_len;
  logic [135:0] sr_q, sr_d;
  resp_mode_t   mode_q, mode_d;
  logic         acc_q, acc_d, valid_q, valid_d, crc_ok_q, crc_ok_d;
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  arg_q, arg_d;
  logic         cmd_q, cmd_d, oe_q, oe_d, ferr_q, ferr_d, tout_q, tout_d;
  logic         crc_clr, crc_en, crc_bit, tx_bit;
  logic [2:0]   crc_sel;
  logic [6:0]   crc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clk_sync_q <= '0;
      cmd_sync_q <= '1;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sd_clk_i};
      cmd_sync_q <= {cmd_sync_q[SYNC_STAGES-2:0], sd_cmd_i};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign cmd_s = cmd_sync_q[SYNC_STAGES-1];
  assign rise  = clk_s & ~clk_prev_q;
  assign fall  = ~clk_s & clk_prev_q;

  neosd_crc7 u_crc (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(crc_clr), .en_i(crc_en),
    .bit_i(crc_bit), .crc_o(crc)
  );

  // R1 bits 40..46 come from the running CRC rather than the shifter.
  assign tx_len  = (mode_q == RESP_R2) ? 8'(RESP_LONG_BITS) : 8'(CMD_FRAME_BITS);
  assign crc_sel = 3'(8'd46 - cnt_q);
  assign tx_bit  = (mode_q == RESP_R1 && cnt_q >= 8'd40 && cnt_q <= 8'd46) ?
                   crc[crc_sel] : sr_q[135];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fall_cnt_d = fall_cnt_q;
    sr_d       = sr_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    valid_d    = valid_q;
    crc_ok_d   = crc_ok_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    cmd_d      = cmd_q;
    oe_d       = oe_q;
    ferr_d     = 1'b0;
    tout_d     = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_bit    = cmd_s;
    case (state_q)
      S_IDLE: begin
        crc_clr = 1'b1;
        if (rise && !cmd_s) begin
          crc_en  = 1'b1;
          sr_d    = {sr_q[134:0], cmd_s};
          cnt_d   = 8'd1;
          state_d = S_RX;
        end
      end
      S_RX: if (rise) begin
        sr_d   = {sr_q[134:0], cmd_s};
        cnt_d  = cnt_q + 8'd1;
        crc_en = (cnt_q < 8'd40);
        if (cnt_q == LAST_RX) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!sr_q[46] || !sr_q[0]) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d      = sr_q[45:40];
          arg_d      = sr_q[39:8];
          crc_ok_d   = (crc == sr_q[7:1]);
          valid_d    = 1'b1;
          acc_d      = 1'b0;
          fall_cnt_d = 8'd0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        crc_clr = 1'b1;
        if (fall) fall_cnt_d = fall_cnt_q + 8'd1;
        if (valid_q && bif.resp_valid_i) begin
          valid_d = 1'b0;
          mode_d  = bif.resp_mode_i;
          sr_d    = resp_frame(bif.resp_mode_i, bif.resp_idx_i, bif.resp_data_i);
          if (bif.resp_mode_i == RESP_NONE) state_d = S_IDLE;
          else                              acc_d   = 1'b1;
        end else if (acc_q && fall && (fall_cnt_q + 8'd1) >= NCR_MIN_C) begin
          cmd_d   = sr_q[135];
          oe_d    = 1'b1;
          sr_d    = {sr_q[134:0], 1'b0};
          cnt_d   = 8'd1;
          crc_en  = 1'b1;
          crc_bit = sr_q[135];
          state_d = S_TX;
        end else if (!acc_q && fall && (fall_cnt_q + 8'd1) >= NCR_MAX_C) begin
          tout_d  = 1'b1;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_TX: if (fall) begin
        if (cnt_q == tx_len) begin
          state_d = S_TURN;
        end else begin
          cmd_d   = tx_bit;
          sr_d    = {sr_q[134:0], 1'b0};
          cnt_d   = cnt_q + 8'd1;
          crc_en  = (cnt_q < 8'd40);
          crc_bit = tx_bit;
        end
      end
      S_TURN: if (fall) begin
        oe_d    = 1'b0;
        cmd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fsm_rst_i) begin
      state_d = S_IDLE; cnt_d = '0; fall_cnt_d = '0; sr_d = '0; mode_d = RESP_NONE;
      acc_d = 1'b0; valid_d = 1'b0; crc_ok_d = 1'b0; idx_d = '0; arg_d = '0;
      cmd_d = 1'b1; oe_d = 1'b0; ferr_d = 1'b0; tout_d = 1'b0; crc_clr = 1'b1; crc_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE; cnt_q <= '0; fall_cnt_q <= '0; sr_q <= '0; mode_q <= RESP_NONE;
      acc_q <= 1'b0; valid_q <= 1'b0; crc_ok_q <= 1'b0; idx_q <= '0; arg_q <= '0;
      cmd_q <= 1'b1; oe_q <= 1'b0; ferr_q <= 1'b0; tout_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; fall_cnt_q <= fall_cnt_d; sr_q <= sr_d; mode_q <= mode_d;
      acc_q <= acc_d; valid_q <= valid_d; crc_ok_q <= crc_ok_d; idx_q <= idx_d; arg_q <= arg_d;
      cmd_q <= cmd_d; oe_q <= oe_d; ferr_q <= ferr_d; tout_q <= tout_d;
    end
  end

  assign sd_cmd_o         = cmd_q;
  assign sd_cmd_oe        = oe_q;
  assign bif.cmd_valid_o  = valid_q;
  assign bif.cmd_idx_o    = idx_q;
  assign bif.cmd_arg_o    = arg_q;
  assign bif.cmd_crc_ok_o = crc_ok_q;
  assign busy_o           = (state_q != S_IDLE);
  assign frame_err_o      = ferr_q;
  assign timeout_o        = tout_q;
endmodule

// File: tb/tb_neosd_card_cmd.sv
// Bench for neosd_card_cmd: acts as SD host, drives sd_clk, checks against a frame-level model.
module tb_neosd_card_cmd;
  import neosd_card_cmd_pkg::*;

  localparam int NCR_MIN = 2;
  localparam int NCR_MAX = 64;
  localparam int HALF    = 40;

  logic clk = 1'b0;
  logic rstn, fsm_rst, sd_clk, sd_cmd_i, sd_cmd_o, sd_cmd_oe, busy, ferr, tout;
  int   errors = 0, checks = 0, n_ferr = 0, n_tout = 0;

  neosd_card_cmd_if bif ();

  neosd_card_cmd #(.SYNC_STAGES(2), .NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
    .clk_i(clk), .rstn_i(rstn), .fsm_rst_i(fsm_rst), .sd_clk_i(sd_clk),
    .sd_cmd_i(sd_cmd_i), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .bif(bif),
    .busy_o(busy), .frame_err_o(ferr), .timeout_o(tout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ferr) n_ferr <= n_ferr + 1;
    if (tout) n_tout <= n_tout + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as polynomial long division: remainder of M(x)*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [135:0] exp_resp(input resp_mode_t m, input logic [5:0] idx,
                                            input logic [127:0] d);
    case (m)
      RESP_R1: return {88'h0, 2'b00, idx, d[31:0], crc7_ref({2'b00, idx, d[31:0]}), 1'b1};
      RESP_R3: return {88'h0, 2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1};
      RESP_R2: return {2'b00, 6'h3F, d[127:1], 1'b1};
      default: return '0;
    endcase
  endfunction

  // One sd_clk period: host drives on the fall, samples the card line just before the rise.
  task automatic sd_tick(input logic hb, output logic lb, output logic loe);
    sd_clk = 1'b0; sd_cmd_i = hb;
    #HALF;
    lb = sd_cmd_o; loe = sd_cmd_oe;
    sd_clk = 1'b1;
    #HALF;
  endtask

  task automatic send_cmd(input logic [47:0] f);
    logic b, oe;
    for (int i = 47; i >= 0; i--) sd_tick(f[i], b, oe);
  endtask

  task automatic check_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic crc_ok);
    check({tag, "_valid"}, 136'(bif.cmd_valid_o), 136'(1'b1));
    check({tag, "_idx"},   136'(bif.cmd_idx_o), 136'(idx));
    check({tag, "_arg"},   136'(bif.cmd_arg_o), 136'(arg));
    check({tag, "_crcok"}, 136'(bif.cmd_crc_ok_o), 136'(crc_ok));
  endtask

  task automatic respond(input resp_mode_t mode, input logic [5:0] idx, input logic [127:0] data,
                         input int delay, output logic [135:0] got);
    logic b, oe, any_oe;
    int   len, exp_start, start_tick, nb;
    got = '0; any_oe = 1'b0;
    for (int t = 0; t < delay; t++) begin
      sd_tick(1'b1, b, oe);
      any_oe |= oe;
    end
    bif.resp_valid_i = 1'b1; bif.resp_mode_i = mode;
    bif.resp_idx_i = idx;    bif.resp_data_i = data;
    #10;
    bif.resp_valid_i = 1'b0;
    check("accept_drops_valid", 136'(bif.cmd_valid_o), 136'(1'b0));
    if (mode == RESP_NONE) begin
      for (int t = 0; t < 3; t++) begin
        sd_tick(1'b1, b, oe);
        any_oe |= oe;
      end
      check("none_no_oe", 136'(any_oe), 136'(1'b0));
      check("none_idle", 136'(busy), 136'(1'b0));
    end else begin
      len = (mode == RESP_R2) ? 136 : 48;
      exp_start = (delay + 1 > NCR_MIN) ? delay + 1 : NCR_MIN;
      start_tick = 0; nb = 0;
      for (int t = delay + 1; t <= exp_start + len + 2; t++) begin
        sd_tick(1'b1, b, oe);
        if (oe) begin
          if (start_tick == 0) start_tick = t;
          if (nb < len) begin
            got = {got[134:0], b};
            nb++;
          end
        end
      end
      check("pre_accept_oe", 136'(any_oe), 136'(1'b0));
      check("start_fall", 136'(start_tick), 136'(exp_start));
      check("resp_frame", got, exp_resp(mode, idx, data));
      check("released", 136'({sd_cmd_oe, sd_cmd_o, busy}), 136'(3'b010));
    end
  endtask

  initial begin
    logic [135:0] got;
    logic [127:0] d;
    logic [31:0]  arg;
    logic [5:0]   idx;
    logic [47:0]  f;
    logic         b, oe, bad, any_oe;
    resp_mode_t   m;
    int           n0, nb;

    rstn = 1'b0; fsm_rst = 1'b0; sd_clk = 1'b1; sd_cmd_i = 1'b1;
    bif.resp_valid_i = 1'b0; bif.resp_mode_i = RESP_NONE;
    bif.resp_idx_i = '0; bif.resp_data_i = '0;
    #23 rstn = 1'b1;
    #20;
    check("rst_line", 136'({sd_cmd_oe, sd_cmd_o}), 136'(2'b01));
    check("rst_outs", 136'({bif.cmd_valid_o, busy, ferr, tout}), 136'(4'b0000));

    // CMD0, back-end declines to answer
    send_cmd(48'h400000000095);
    check_cmd("cmd0", 6'd0, 32'd0, 1'b1);
    respond(RESP_NONE, 6'd0, '0, 0, got);

    // CMD8 with immediate R1
    send_cmd(48'h48000001AA87);
    check_cmd("cmd8", 6'd8, 32'h1AA, 1'b1);
    respond(RESP_R1, 6'd8, 128'h1AA, 0, got);

    // CMD17 R1 against a known line pattern
    send_cmd(mk_frame(6'd17, 32'h0000_0900));
    check_cmd("cmd17", 6'd17, 32'h900, 1'b1);
    respond(RESP_R1, 6'h11, 128'h900, 0, got);
    check("cmd17_line", got, 136'h110000090067);

    // CMD2 with a long R2 (CID)
    send_cmd(mk_frame(6'd2, 32'd0));
    d = {$urandom, $urandom, $urandom, $urandom};
    respond(RESP_R2, 6'd2, d, 1, got);
    check("r2_header", 136'(got[135:128]), 136'(8'h3F));

    // corrupted CRC still presented
    send_cmd(48'h400000000097);
    check_cmd("crcbad", 6'd0, 32'd0, 1'b0);
    respond(RESP_NONE, 6'd0, '0, 0, got);

    // transmission bit cleared: foreign traffic
    n0 = n_ferr;
    send_cmd(48'h000000000095);
    #20;
    check("ferr_pulse", 136'(n_ferr), 136'(n0 + 1));
    check("ferr_no_valid", 136'({bif.cmd_valid_o, busy}), 136'(2'b00));

    // no response within NCR_MAX falls
    n0 = n_tout;
    send_cmd(mk_frame(6'd55, $urandom));
    for (int t = 1; t < NCR_MAX; t++) sd_tick(1'b1, b, oe);
    check("tout_not_early", 136'({n_tout == n0, bif.cmd_valid_o}), 136'(2'b11));
    sd_tick(1'b1, b, oe);
    check("tout_pulse", 136'(n_tout), 136'(n0 + 1));
    check("tout_state", 136'({bif.cmd_valid_o, sd_cmd_oe, busy}), 136'(3'b000));

    // soft reset while waiting, then a stray offer while idle
    send_cmd(mk_frame(6'd13, 32'h1234_0000));
    fsm_rst = 1'b1; #10; fsm_rst = 1'b0;
    check("fsmrst", 136'({bif.cmd_valid_o, busy}), 136'(2'b00));
    bif.resp_valid_i = 1'b1; bif.resp_mode_i = RESP_R1;
    any_oe = 1'b0;
    for (int t = 0; t < 4; t++) begin
      sd_tick(1'b1, b, oe);
      any_oe |= oe;
    end
    bif.resp_valid_i = 1'b0;
    check("stray_resp_ignored", 136'({any_oe, busy}), 136'(2'b00));

    // async reset in the middle of a response
    send_cmd(mk_frame(6'd17, 32'h0000_0900));
    bif.resp_valid_i = 1'b1; bif.resp_mode_i = RESP_R1;
    bif.resp_idx_i = 6'h11; bif.resp_data_i = 128'h900;
    #10;
    bif.resp_valid_i = 1'b0;
    nb = 0;
    for (int t = 0; t < 40 && nb < 21; t++) begin
      sd_tick(1'b1, b, oe);
      if (oe) nb++;
    end
    check("midtx_bits", 136'(nb), 136'(21));
    rstn = 1'b0;
    #1;
    check("midtx_release", 136'({sd_cmd_oe, sd_cmd_o, busy}), 136'(3'b010));
    #19 rstn = 1'b1;
    #60;
    send_cmd(mk_frame(6'd9, 32'hCAFE_0000));
    check_cmd("after_rst", 6'd9, 32'hCAFE_0000, 1'b1);
    respond(RESP_R1, 6'd9, 128'h0000_0F00, 0, got);

    // randomized commands and responses
    for (int n = 0; n < 6; n++) begin
      idx = 6'($urandom_range(0, 63));
      arg = $urandom;
      f   = mk_frame(idx, arg);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) f = f ^ (48'h1 << $urandom_range(1, 7));
      send_cmd(f);
      check_cmd("rand_cmd", idx, arg, !bad);
      m = bad ? RESP_NONE : resp_mode_t'($urandom_range(0, 3));
      d = {$urandom, $urandom, $urandom, $urandom};
      respond(m, idx, d, $urandom_range(0, 4), got);
    end

    check("ferr_total", 136'(n_ferr), 136'(1));
    check("tout_total", 136'(n_tout), 136'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
